// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared IF/ID widths, NOP opcode, fetch states and slot type
// Used by fetch_inject_reg and replay_buf.
package pipeline_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 32;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  // REPLAY is reserved for FETCH_REPLAY_EN builds; the buffered slot is issued
  // directly on the injection exit edge, so the state is never entered.
  typedef enum logic [1:0] {
    PASS   = 2'd0,
    INJECT = 2'd1,
    REPLAY = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_slot_t;

endpackage

// File: rtl/replay_buf.sv
// rtl/replay_buf.sv - one-entry holding buffer for the fetch slot displaced by an injection
// Clear has priority over capture.
module replay_buf
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        clear,
  input  fetch_slot_t din,
  output fetch_slot_t dout,
  output logic        valid
);

  fetch_slot_t data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      data  <= din;
      valid <= 1'b1;
    end
  end

  assign dout = data;

endmodule

// File: rtl/fetch_inject_reg.sv
// rtl/fetch_inject_reg.sv - IF/ID register with sequencer opcode injection
// Optional feature: FETCH_REPLAY_EN keeps the displaced fetch and reissues it on exit.
module fetch_inject_reg
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] inj_instr,
  input  logic               inj_stall,
  input  logic               discard_replay,
  input  logic               hazard_stall,
  input  logic               flush,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic               pc_hold,
  output logic               inj_active
);

  fetch_state_e       state, state_next;
  logic [INSTR_W-1:0] instr_next;
  logic [PC_W-1:0]    pc_next;
  logic               valid_next;
  logic               buf_capture, buf_clear, replay_hit;
  fetch_slot_t        buf_slot;

`ifdef FETCH_REPLAY_EN
  logic buf_valid;

  replay_buf u_replay_buf (
    .clk     (clk),
    .reset   (reset),
    .capture (buf_capture),
    .clear   (buf_clear),
    .din     ('{instr: imem_instr, pc: pc_in}),
    .dout    (buf_slot),
    .valid   (buf_valid)
  );

  assign replay_hit = buf_valid & ~discard_replay;
  // The live fetch is parked in the buffer, so the PC may advance on entry.
  assign pc_hold    = hazard_stall | (state == INJECT);
`else
  logic unused_replay;

  assign unused_replay = ^{buf_capture, buf_clear, discard_replay};
  assign replay_hit    = 1'b0;
  assign buf_slot      = '0;
  assign pc_hold       = hazard_stall | inj_stall | (state == INJECT);
`endif

  assign inj_active = (state == INJECT);

  always_comb begin
    state_next  = state;
    instr_next  = ifid_instr;
    pc_next     = ifid_pc;
    valid_next  = ifid_valid;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    case (state)
      INJECT: begin
        // Flush only affects the parked slot; the sequencer owns IF/ID here.
        if (flush) buf_clear = 1'b1;
        if (inj_stall) begin
          instr_next = inj_instr;
          valid_next = 1'b1;
        end else begin
          state_next = PASS;
          valid_next = 1'b1;
          buf_clear  = 1'b1;
          if (replay_hit && !flush) begin
            instr_next = buf_slot.instr;
            pc_next    = buf_slot.pc;
          end else begin
            instr_next = imem_instr;
            pc_next    = pc_in;
          end
        end
      end
      default: begin
        state_next = PASS;
        if (flush) begin
          instr_next = NOP;
          valid_next = 1'b0;
          buf_clear  = 1'b1;
        end else if (inj_stall) begin
          instr_next  = inj_instr;
          valid_next  = 1'b1;
          state_next  = INJECT;
          buf_capture = 1'b1;
        end else if (!hazard_stall) begin
          instr_next = imem_instr;
          pc_next    = pc_in;
          valid_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= PASS;
      ifid_instr <= NOP;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_next;
      ifid_instr <= instr_next;
      ifid_pc    <= pc_next;
      ifid_valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_inject_reg.sv
// tb/tb_fetch_inject_reg.sv - self-checking bench for fetch_inject_reg (default and FETCH_REPLAY_EN builds)
module tb_fetch_inject_reg;

`ifdef FETCH_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_instr, inj_instr;
  logic [31:0] pc_in;
  logic        inj_stall, discard_replay, hazard_stall, flush;
  logic [15:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid, pc_hold, inj_active;

  int checks = 0;
  int errors = 0;

  fetch_inject_reg dut (
    .clk            (clk),
    .reset          (reset),
    .imem_instr     (imem_instr),
    .pc_in          (pc_in),
    .inj_instr      (inj_instr),
    .inj_stall      (inj_stall),
    .discard_replay (discard_replay),
    .hazard_stall   (hazard_stall),
    .flush          (flush),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_valid     (ifid_valid),
    .pc_hold        (pc_hold),
    .inj_active     (inj_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what IF/ID must hold, whether an injection is running,
  // and which fetch slot (if any) is owed to the pipeline afterwards.
  logic [15:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_inj;
  logic [47:0] saved[$];
  bit          m_started = 1'b0;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (!reset) begin
      m_instr = 16'h0; m_pc = 32'h0; m_valid = 1'b0; m_inj = 1'b0;
      saved.delete();
    end else if (m_inj) begin
      if (flush) saved.delete();
      if (inj_stall) begin
        m_instr = inj_instr; m_valid = 1'b1;
      end else begin
        if (REPLAY && saved.size() != 0 && !discard_replay) {m_instr, m_pc} = saved.pop_front();
        else {m_instr, m_pc} = {imem_instr, pc_in};
        m_valid = 1'b1; m_inj = 1'b0;
        saved.delete();
      end
    end else if (flush) begin
      m_instr = 16'h0; m_valid = 1'b0;
      saved.delete();
    end else if (inj_stall) begin
      m_instr = inj_instr; m_valid = 1'b1; m_inj = 1'b1;
      if (REPLAY) saved.push_back({imem_instr, pc_in});
    end else if (!hazard_stall) begin
      {m_instr, m_pc} = {imem_instr, pc_in};
      m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("model_instr", {32'h0, ifid_instr}, {32'h0, m_instr});
      chk("model_pc", {16'h0, ifid_pc}, {16'h0, m_pc});
      chk("model_valid", {47'h0, ifid_valid}, {47'h0, m_valid});
      chk("model_inj_active", {47'h0, inj_active}, {47'h0, m_inj});
      chk("model_pc_hold", {47'h0, pc_hold},
          {47'h0, hazard_stall | m_inj | (!REPLAY & inj_stall)});
    end
  end

  task automatic drive(input logic rst, input logic [15:0] im, input logic [31:0] pc,
                       input logic [15:0] inj, input logic is, input logic dr,
                       input logic hz, input logic fl);
    reset = rst; imem_instr = im; pc_in = pc; inj_instr = inj;
    inj_stall = is; discard_replay = dr; hazard_stall = hz; flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] inj_seq [6];

  initial begin
    inj_seq = '{16'h6089, 16'h6088, 16'h608A, 16'h0000, 16'h0000, 16'h0000};
    drive(0, 16'h0, 32'h0, 16'h0, 0, 0, 0, 0);
    tick; tick;
    chk("reset_instr", {32'h0, ifid_instr}, 48'h0);
    chk("reset_pc", {16'h0, ifid_pc}, 48'h0);
    chk("reset_valid", {47'h0, ifid_valid}, 48'h0);
    chk("reset_inj_active", {47'h0, inj_active}, 48'h0);
    chk("reset_pc_hold", {47'h0, pc_hold}, 48'h0);

    drive(1, 16'h1234, 32'h10, 16'h0, 0, 0, 0, 0);
    tick;
    chk("fetch_instr", {32'h0, ifid_instr}, 48'h1234);
    chk("fetch_pc", {16'h0, ifid_pc}, 48'h10);
    chk("fetch_valid", {47'h0, ifid_valid}, 48'h1);
    chk("fetch_pc_hold", {47'h0, pc_hold}, 48'h0);

    for (int i = 0; i < 6; i++) begin
      drive(1, 16'h1111, 32'h11, inj_seq[i], 1, 0, 0, 0);
      if (i == 0) begin
        #1;
        chk("entry_pc_hold", {47'h0, pc_hold}, REPLAY ? 48'h0 : 48'h1);
      end
      tick;
      chk("inj_seq_instr", {32'h0, ifid_instr}, {32'h0, inj_seq[i]});
      chk("inj_seq_pc", {16'h0, ifid_pc}, 48'h10);
      chk("inj_seq_pc_hold", {47'h0, pc_hold}, 48'h1);
    end
    drive(1, 16'h1111, 32'h11, 16'h0, 0, 0, 0, 0);
    tick;
    chk("exit_instr", {32'h0, ifid_instr}, 48'h1111);
    chk("exit_inj_active", {47'h0, inj_active}, 48'h0);

    drive(1, 16'hABCD, 32'h20, 16'h6001, 1, 0, 0, 0);
    tick;
    chk("replay_entry_pc", {16'h0, ifid_pc}, 48'h11);
    drive(1, 16'h5555, 32'h21, 16'h6002, 1, 0, 0, 0);
    tick;
    drive(1, 16'h5555, 32'h21, 16'h0, 0, 0, 0, 0);
    tick;
    chk("replay_exit_instr", {32'h0, ifid_instr}, REPLAY ? 48'hABCD : 48'h5555);
    chk("replay_exit_pc", {16'h0, ifid_pc}, REPLAY ? 48'h20 : 48'h21);
    tick;
    chk("replay_next_pc", {16'h0, ifid_pc}, 48'h21);

    drive(1, 16'hAAAA, 32'h3F, 16'h6003, 1, 0, 0, 0);
    tick;
    drive(1, 16'h7777, 32'h40, 16'h6004, 1, 0, 0, 0);
    tick;
    drive(1, 16'h7777, 32'h40, 16'h0, 0, 1, 0, 0);
    tick;
    chk("discard_instr", {32'h0, ifid_instr}, 48'h7777);
    chk("discard_pc", {16'h0, ifid_pc}, 48'h40);

    drive(1, 16'h2222, 32'h50, 16'h6010, 1, 0, 0, 0);
    tick;
    drive(1, 16'h3333, 32'h51, 16'h6011, 1, 0, 1, 1);
    tick;
    chk("inj_flush_instr", {32'h0, ifid_instr}, 48'h6011);
    chk("inj_flush_valid", {47'h0, ifid_valid}, 48'h1);
    drive(1, 16'h3333, 32'h51, 16'h0, 0, 0, 0, 0);
    tick;
    chk("flushed_buf_exit", {32'h0, ifid_instr}, 48'h3333);
    drive(1, 16'h4444, 32'h52, 16'h0, 0, 0, 1, 0);
    #1;
    chk("hazard_pc_hold", {47'h0, pc_hold}, 48'h1);
    tick;
    chk("hazard_hold_instr", {32'h0, ifid_instr}, 48'h3333);
    drive(1, 16'h4444, 32'h52, 16'h0, 0, 0, 0, 1);
    tick;
    chk("pass_flush_valid", {47'h0, ifid_valid}, 48'h0);
    chk("pass_flush_instr", {32'h0, ifid_instr}, 48'h0);
    drive(1, 16'h4444, 32'h52, 16'h6020, 1, 0, 0, 1);
    tick;
    chk("flush_beats_inject", {47'h0, inj_active}, 48'h0);

    drive(1, 16'h5151, 32'h60, 16'h6030, 1, 0, 0, 0);
    tick;
    drive(1, 16'h5151, 32'h61, 16'h6031, 1, 0, 0, 0);
    tick;
    drive(0, 16'h5151, 32'h61, 16'h6032, 1, 0, 0, 0);
    tick;
    chk("midinj_reset_instr", {32'h0, ifid_instr}, 48'h0);
    chk("midinj_reset_pc", {16'h0, ifid_pc}, 48'h0);
    chk("midinj_reset_valid", {47'h0, ifid_valid}, 48'h0);
    chk("midinj_reset_inj_active", {47'h0, inj_active}, 48'h0);
    drive(1, 16'h0, 32'h0, 16'h0, 0, 0, 0, 0);
    #1;
    chk("post_reset_pc_hold", {47'h0, pc_hold}, 48'h0);
    tick;
    drive(1, 16'h9999, 32'h70, 16'h0, 0, 0, 0, 0);
    tick;
    chk("post_reset_fetch", {32'h0, ifid_instr}, 48'h9999);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
